// File: rtl/iguana_reg_timeout.sv
// Register-interface timeout guard: forwards register accesses and aborts
// with an error response when the downstream slave stalls for too long.

package iguana_reg_timeout_pkg;

  // Register request payload toward a register slave.
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  // Register response payload back to the master.
  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;

endpackage

module iguana_reg_timeout #(
  parameter type         reg_req_t     = iguana_reg_timeout_pkg::reg_req_t,
  parameter type         reg_rsp_t     = iguana_reg_timeout_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 256,
  parameter int unsigned HoldoffCycles = 16,
  parameter logic [31:0] ErrData       = 32'hBADC_AB1E
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  reg_req_t   reg_req_i,
  output reg_rsp_t   reg_rsp_o,
  output reg_req_t   reg_req_o,
  input  reg_rsp_t   reg_rsp_i,
  output logic       timeout_o,
  output logic [7:0] tmo_count_o
);

  localparam int unsigned CntW     = $clog2(TimeoutCycles + 1);
  localparam int unsigned HoldW    = (HoldoffCycles > 1) ? $clog2(HoldoffCycles) : 1;
  localparam int unsigned CntLast  = TimeoutCycles - 1;
  localparam int unsigned HoldLast = (HoldoffCycles > 0) ? HoldoffCycles - 1 : 0;
  localparam logic [7:0]  CountMax = 8'hFF;

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    ABORT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [7:0]       tmo_count_q, tmo_count_d;
  logic             stall;

  // A forwarded access that the slave is not accepting this cycle.
  assign stall = reg_req_i.valid && !reg_rsp_i.ready;

  assign tmo_count_o = tmo_count_q;

  // State and counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= PASS;
      cnt_q       <= '0;
      hold_q      <= '0;
      tmo_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      tmo_count_q <= tmo_count_d;
    end
  end

  // Next state, counters and the muxed request/response paths.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    hold_d      = '0;
    tmo_count_d = clr_i ? 8'd0 : tmo_count_q;
    reg_req_o   = reg_req_i;
    reg_rsp_o   = reg_rsp_i;
    timeout_o   = 1'b0;

    unique case (state_q)
      PASS: begin
        if (stall) begin
          if (cnt_q == CntW'(CntLast)) begin
            state_d = ABORT;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end

      ABORT: begin
        // Complete the master's held access with an error; hide it from the slave.
        reg_req_o.valid = 1'b0;
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = ErrData;
        reg_rsp_o.error = 1'b1;
        reg_rsp_o.ready = 1'b1;
        timeout_o       = 1'b1;
        if (tmo_count_d != CountMax) begin
          tmo_count_d = tmo_count_d + 8'd1;
        end
        state_d = (HoldoffCycles > 0) ? HOLD : PASS;
      end

      HOLD: begin
        // Isolate the slave and stall new master requests.
        reg_req_o.valid = 1'b0;
        reg_rsp_o       = '0;
        if (hold_q == HoldW'(HoldLast)) begin
          state_d = PASS;
        end else begin
          hold_d = hold_q + HoldW'(1);
        end
      end

      default: state_d = PASS;
    endcase
  end

endmodule

// File: tb/tb_iguana_reg_timeout.sv
// Randomized and directed bench for iguana_reg_timeout against a cycle-number model.

module tb_iguana_reg_timeout;
  import iguana_reg_timeout_pkg::*;

  localparam int unsigned T   = 8;
  localparam int unsigned H   = 4;
  localparam logic [31:0] ERR = 32'hBADC_AB1E;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr   = 1'b0;
  reg_req_t   req_i, req_o;
  reg_rsp_t   rsp_i, rsp_o;
  logic       timeout;
  logic [7:0] tmo_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iguana_reg_timeout #(
    .reg_req_t    (reg_req_t),
    .reg_rsp_t    (reg_rsp_t),
    .TimeoutCycles(T),
    .HoldoffCycles(H),
    .ErrData      (ERR)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clr_i      (clr),
    .reg_req_i  (req_i),
    .reg_rsp_o  (rsp_o),
    .reg_req_o  (req_o),
    .reg_rsp_i  (rsp_i),
    .timeout_o  (timeout),
    .tmo_count_o(tmo_count)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the abort cycle is the cycle after the T-th consecutive stalled
  // cycle of one access; the following H cycles are isolated.
  int cyc          = 0;
  int abort_cyc    = -100;
  int stall_start  = -1;
  int count_m      = 0;
  int m_aborts     = 0;
  bit m_hs         = 1'b0;
  bit m_abort_next = 1'b0;

  // Compare DUT against the model on every cycle, then advance the model.
  always @(negedge clk) begin
    reg_req_t e_req;
    reg_rsp_t e_rsp;
    bit in_abort, in_hold;
    if (!rst_n) begin
      check("rst_req_o", req_o, req_i);
      check("rst_rsp_o", rsp_o, rsp_i);
      check("rst_timeout_o", timeout, 1'b0);
      check("rst_tmo_count_o", tmo_count, 8'd0);
      abort_cyc    = -100;
      stall_start  = -1;
      count_m      = 0;
      m_hs         = 1'b0;
      m_abort_next = 1'b0;
    end else begin
      in_abort = (cyc == abort_cyc);
      in_hold  = (cyc > abort_cyc) && (cyc <= abort_cyc + int'(H));
      e_req = req_i;
      e_rsp = rsp_i;
      if (in_abort || in_hold) e_req.valid = 1'b0;
      if (in_abort) begin
        e_rsp.rdata = ERR;
        e_rsp.error = 1'b1;
        e_rsp.ready = 1'b1;
      end else if (in_hold) begin
        e_rsp = '0;
      end
      if (in_hold) check("hold_req_valid", req_o.valid, 1'b0);
      else         check("req_o", req_o, e_req);
      check("rsp_o", rsp_o, e_rsp);
      check("timeout_o", timeout, in_abort);
      check("tmo_count_o", tmo_count, 128'(count_m));

      m_hs = req_i.valid && e_rsp.ready;
      if (in_abort) begin
        m_aborts++;
        count_m = clr ? 1 : ((count_m < 255) ? count_m + 1 : 255);
      end else if (clr) begin
        count_m = 0;
      end
      m_abort_next = 1'b0;
      if (!in_abort && !in_hold && req_i.valid && !rsp_i.ready) begin
        if (stall_start < 0) stall_start = cyc;
        if (cyc - stall_start == int'(T) - 1) begin
          abort_cyc    = cyc + 1;
          stall_start  = -1;
          m_abort_next = 1'b1;
        end
      end else begin
        stall_start = -1;
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_req();
    req_i.addr  = $urandom;
    req_i.write = 1'($urandom_range(1));
    req_i.wdata = $urandom;
    req_i.wstrb = 4'($urandom);
    req_i.valid = 1'b1;
  endtask

  // Protocol-abiding master: holds a request until the model sees its handshake.
  task automatic drive_master(input int p_valid);
    if (!req_i.valid || m_hs) begin
      if (int'($urandom_range(99)) < p_valid) new_req();
      else req_i.valid = 1'b0;
    end
  endtask

  task automatic drive_slave(input int p_ready);
    rsp_i.ready = (int'($urandom_range(99)) < p_ready);
    rsp_i.rdata = $urandom;
    rsp_i.error = ($urandom_range(7) == 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_cnt, target, budget, p_v, p_r;
    bit seen;
    req_i = '0;
    rsp_i = '0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_count", tmo_count, 8'd0);
    check("reset_timeout", timeout, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-latency slave, 4 back-to-back reads
    for (int k = 0; k < 4; k++) begin
      tick();
      req_i       = '0;
      req_i.addr  = 32'h100 + 32'(k);
      req_i.valid = 1'b1;
      rsp_i.ready = 1'b1;
      rsp_i.error = 1'b0;
      rsp_i.rdata = 32'h1000_0000 + 32'(k);
      @(negedge clk);
      check("zl_rdata", rsp_o.rdata, 32'h1000_0000 + 32'(k));
      check("zl_ready", rsp_o.ready, 1'b1);
      check("zl_error", rsp_o.error, 1'b0);
      check("zl_timeout", timeout, 1'b0);
    end
    tick();
    req_i.valid = 1'b0;
    rsp_i.ready = 1'b0;

    // Slave ready in cycle T-1 completes normally
    for (int c = 0; c < int'(T); c++) begin
      tick();
      if (c == 0) new_req();
      rsp_i.ready = (c == int'(T) - 1);
      rsp_i.error = 1'b0;
      rsp_i.rdata = 32'hCAFE_0000 + 32'(c);
      @(negedge clk);
      if (c == int'(T) - 1) begin
        check("late_ready", rsp_o.ready, 1'b1);
        check("late_error", rsp_o.error, 1'b0);
        check("late_rdata", rsp_o.rdata, 32'hCAFE_0007);
        check("late_timeout", timeout, 1'b0);
      end
    end
    tick();
    req_i.valid = 1'b0;
    rsp_i.ready = 1'b0;
    @(negedge clk);
    check("late_count", tmo_count, 8'd0);

    // Slave never ready; stray readies during ABORT and HOLD
    hs_cnt = 0;
    for (int c = 0; c <= 13; c++) begin
      tick();
      if (c == 0 || c == 9) new_req();
      rsp_i.ready = (c == 8 || c == 10);
      rsp_i.error = 1'b0;
      rsp_i.rdata = $urandom;
      @(negedge clk);
      if (c == 8) begin
        check("abort_ready", rsp_o.ready, 1'b1);
        check("abort_error", rsp_o.error, 1'b1);
        check("abort_rdata", rsp_o.rdata, 32'hBADC_AB1E);
        check("abort_timeout", timeout, 1'b1);
      end
      if (c == 7) check("pre_abort_timeout", timeout, 1'b0);
      if (c >= 8 && c <= 12) begin
        check("isolate_valid", req_o.valid, 1'b0);
        if (req_i.valid && rsp_o.ready) hs_cnt++;
      end
      if (c == 8) check("abort_count_old", tmo_count, 8'd0);
      if (c == 9) check("abort_count_new", tmo_count, 8'd1);
      if (c == 13) check("fwd_after_hold", req_o.valid, 1'b1);
    end
    check("single_completion", 32'(hs_cnt), 32'd1);
    tick();
    rsp_i.ready = 1'b1;
    tick();
    req_i.valid = 1'b0;
    rsp_i.ready = 1'b0;

    // 300 forced timeouts saturate the counter
    target = m_aborts + 300;
    budget = 300 * int'(T + H + 2) + 100;
    seen   = 1'b0;
    while (budget > 0) begin
      tick();
      if (m_aborts >= target) begin
        seen = 1'b1;
        break;
      end
      drive_master(100);
      rsp_i.ready = 1'b0;
      budget--;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL sat_wait: got %0d aborts expected %0d", m_aborts, target);
    end
    @(negedge clk);
    check("sat_count", tmo_count, 8'd255);

    // Clear coinciding with an ABORT cycle
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (m_abort_next) begin
        clr  = 1'b1;
        seen = 1'b1;
        break;
      end
      drive_master(100);
      rsp_i.ready = 1'b0;
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL clr_wait: got no abort expected one within 100 cycles");
    end
    @(negedge clk);
    check("clr_abort_timeout", timeout, 1'b1);
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("clr_abort_count", tmo_count, 8'd1);

    // Idle, then reset in cycle 5 of a stalled access
    req_i.valid = 1'b0;
    rsp_i.ready = 1'b0;
    repeat (10) tick();
    for (int c = 0; c <= 15; c++) begin
      tick();
      if (c == 0) new_req();
      rsp_i.ready = 1'b0;
      if (c == 5) rst_n = 1'b0;
      if (c == 6) rst_n = 1'b1;
      @(negedge clk);
      if (c == 6) begin
        check("post_rst_count", tmo_count, 8'd0);
        check("post_rst_timeout", timeout, 1'b0);
      end
      if (c == 13) check("post_rst_no_abort", timeout, 1'b0);
      if (c == 14) check("post_rst_abort", timeout, 1'b1);
    end

    // Randomized traffic with varying slave latency and occasional clears
    for (int ph = 0; ph < 6; ph++) begin
      p_v = 30 + 14 * ph;
      p_r = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 30 : 80);
      for (int i = 0; i < 500; i++) begin
        tick();
        drive_master(p_v);
        drive_slave(p_r);
        clr = ($urandom_range(99) == 0);
      end
    end
    tick();
    clr         = 1'b0;
    req_i.valid = 1'b0;
    rsp_i.ready = 1'b0;
    repeat (20) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
